fifo_wr_ctrl: RTL and testbench

Write-side controller for the async FIFO. Sits in the write clock domain, accepts write requests, drives the FIFO memory write address and enable, and publishes a registered Gray-coded write pointer for the double-flop synchronizer into the read domain. It consumes the read pointer after that synchronizer has brought it into the write domain, and from it produces full, almost-full, free-slot count and a sticky overflow flag.

---
 rtl/fifo_wr_ctrl_pkg.sv | 5 +
 rtl/fifo_wr_ctrl_if.sv | 18 +
 rtl/fifo_wr_ctrl_gray2bin.sv | 9 +
 rtl/fifo_wr_ctrl.sv | 40 ++++
 tb/tb_fifo_wr_ctrl.sv | 106 ++++++++++
 5 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_wr_ctrl_pkg: shared async FIFO pointer-width and threshold defaults
package fifo_wr_ctrl_pkg;
  localparam int P_SIZE_DEF = 3;
  localparam int AF_LEVEL_DEF = 2;
endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: write-side request, memory and status signals of the async FIFO
import fifo_wr_ctrl_pkg::*;
interface fifo_wr_ctrl_if #(parameter int P_SIZE = P_SIZE_DEF) ();
  logic              w_inc;
  logic [P_SIZE:0]   rd_ptr_sync;
  logic              clr_ovf;
  logic              w_clken;
  logic [P_SIZE-1:0] w_addr;
  logic [P_SIZE:0]   wr_ptr;
  logic              full;
  logic              almost_full;
  logic [P_SIZE:0]   free;
  logic              overflow;
  modport master (output w_inc, rd_ptr_sync, clr_ovf,
                  input w_clken, w_addr, wr_ptr, full, almost_full, free, overflow);
  modport slave (input w_inc, rd_ptr_sync, clr_ovf,
                 output w_clken, w_addr, wr_ptr, full, almost_full, free, overflow);
endinterface

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder, each bit is the xor of all higher Gray bits
module gray2bin #(parameter int W = 4) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointer, full/almost-full/free and sticky overflow
import fifo_wr_ctrl_pkg::*;
module fifo_wr_ctrl #(
  parameter int P_SIZE = P_SIZE_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF
) (
  input logic clk,
  input logic rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam logic [P_SIZE:0] DEPTH = (P_SIZE+1)'(1) << P_SIZE;
  localparam logic [P_SIZE:0] AF = (P_SIZE+1)'(AF_LEVEL);
  logic [P_SIZE:0] wbin, wbin_nx, wr_ptr, rbin, used;
  logic            overflow, full, accept;
  gray2bin #(.W(P_SIZE+1)) u_g2b (.gray(bus.rd_ptr_sync), .bin(rbin));
  assign wbin_nx = wbin + 1'b1;
  // Full when the write pointer is exactly one lap ahead of the synchronized read pointer
  assign full = wr_ptr == {~bus.rd_ptr_sync[P_SIZE:P_SIZE-1], bus.rd_ptr_sync[P_SIZE-2:0]};
  assign accept = bus.w_inc & ~full;
  assign used = wbin - rbin;
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin <= '0;
      wr_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      wbin <= accept ? wbin_nx : wbin;
      wr_ptr <= accept ? wbin_nx ^ (wbin_nx >> 1) : wr_ptr;
      overflow <= (bus.w_inc & full) | (overflow & ~bus.clr_ovf);
    end
  end
  assign bus.w_clken = accept;
  assign bus.w_addr = wbin[P_SIZE-1:0];
  assign bus.wr_ptr = wr_ptr;
  assign bus.full = full;
  // A corrupt read pointer must never make the free count wrap to a large value
  assign bus.free = used > DEPTH ? '0 : DEPTH - used;
  assign bus.almost_full = bus.free <= AF;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: occupancy-model bench with per-cycle compare and hand-computed pins
module tb_fifo_wr_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_run = 0, n_fail = 0;
  int   wc = 0, rc = 0;
  logic ovf = 1'b0;
  always #5 clk = ~clk;
  fifo_wr_ctrl_if #(.P_SIZE(3)) bus ();
  fifo_wr_ctrl #(.P_SIZE(3), .AF_LEVEL(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [3:0] gray(input int x);
    logic [3:0] b;
    b = 4'(x);
    return b ^ (b >> 1);
  endfunction
  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // One clock: drive, compare mid-cycle against the occupancy model, then advance the model
  task automatic cyc(input logic inc, input int r, input logic clr, input logic rs);
    int used, fr;
    logic fl;
    rc = r & 15;
    bus.w_inc = inc;
    bus.rd_ptr_sync = gray(rc);
    bus.clr_ovf = clr;
    rst = rs;
    used = (wc - rc) & 15;
    fl = used == 8;
    fr = used > 8 ? 0 : 8 - used;
    @(negedge clk);
    if (!rs) begin
      check("w_clken", int'(bus.w_clken), int'(inc && !fl));
      check("w_addr", int'(bus.w_addr), wc % 8);
      check("wr_ptr", int'(bus.wr_ptr), int'(gray(wc)));
      check("full", int'(bus.full), int'(fl));
      check("free", int'(bus.free), fr);
      check("almost_full", int'(bus.almost_full), int'(fr <= 2));
      check("overflow", int'(bus.overflow), int'(ovf));
    end
    @(posedge clk);
    if (rs) begin
      wc = 0;
      ovf = 1'b0;
    end else begin
      ovf = (inc && fl) || (ovf && !clr);
      wc = (inc && !fl) ? (wc + 1) % 16 : wc;
    end
    #1;
  endtask
  initial begin
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("rst_wr_ptr", int'(bus.wr_ptr), 0);
    check("rst_w_addr", int'(bus.w_addr), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_free", int'(bus.free), 8);
    check("rst_af", int'(bus.almost_full), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 0, 1'b0, 1'b0);
      if (i == 6) begin
        check("af_after6_free", int'(bus.free), 2);
        check("af_after6", int'(bus.almost_full), 1);
      end
    end
    check("fill_wr_ptr", int'(bus.wr_ptr), 4'b1100);
    check("fill_full", int'(bus.full), 1);
    check("fill_free", int'(bus.free), 0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    check("ovf_set", int'(bus.overflow), 1);
    check("ovf_wr_ptr_hold", int'(bus.wr_ptr), 4'b1100);
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("ovf_sticky", int'(bus.overflow), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("ovf_clr", int'(bus.overflow), 0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    check("ovf_set_wins", int'(bus.overflow), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0);
    check("jump_w_addr", int'(bus.w_addr), 1);
    check("jump_free", int'(bus.free), 2);
    check("jump_af", int'(bus.almost_full), 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, wc - 2, 1'b0, 1'b0);
    check("wrap_wr_ptr", int'(bus.wr_ptr), 4'b1101);
    for (int i = 0; i < 6; i++) cyc(1'b1, 7, 1'b0, 1'b0);
    check("refill_full", int'(bus.full), 1);
    cyc(1'b1, 7, 1'b0, 1'b0);
    check("refill_ovf", int'(bus.overflow), 1);
    cyc(1'b1, 0, 1'b0, 1'b1);
    check("rst2_wr_ptr", int'(bus.wr_ptr), 0);
    check("rst2_w_addr", int'(bus.w_addr), 0);
    check("rst2_full", int'(bus.full), 0);
    check("rst2_free", int'(bus.free), 8);
    check("rst2_af", int'(bus.almost_full), 0);
    check("rst2_ovf", int'(bus.overflow), 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
